// File: rtl/spi_pkg.sv
// Shared SPI master types and limits.
// Types only: no latency and no flow control.
package spi_pkg;

  localparam int SPI_MAX_DATA_W = 32;
  localparam int SPI_MAX_SS     = 8;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    XFER,
    HOLD
  } spi_state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

endpackage

// File: rtl/spi_clk_gen.sv
// SPI divider: tick_o every H = div_i+1 cycles while run_i is high; lead/trail strobes inside XFER.
// The strobes are combinational from the counter. There is no backpressure: the strobes free-run while run_i is high.
module spi_clk_gen #(
  parameter int DIV_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             run_i,
  input  logic             xfer_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o,
  output logic             lead_tick_o,
  output logic             trail_tick_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;
  logic             tick;

  always_comb begin
    tick    = run_i && (cnt_q == div_i);
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (!run_i || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    // phase 0 means the next sclk edge is a leading edge
    if (!xfer_i) begin
      phase_d = 1'b0;
    end else if (tick) begin
      phase_d = ~phase_q;
    end
    tick_o       = tick;
    lead_tick_o  = xfer_i && tick && !phase_q;
    trail_tick_o = xfer_i && tick && phase_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/spi_master.sv
// SPI master: done arrives (2*DATA_W+2)*H+1 cycles after start. A start seen while busy is dropped; there is no queueing.
// Optional SPI_MASTER_LSB_FIRST_EN adds a lsb_first input that selects the bit order per transfer.
import spi_pkg::*;

module spi_master #(
  parameter int  DATA_W = 16,
  parameter int  NUM_SS = 4,
  parameter int  DIV_W  = 8,
  localparam int SS_W   = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [SS_W-1:0]   ss_sel,
  input  logic              cpol,
  input  logic              cpha,
`ifdef SPI_MASTER_LSB_FIRST_EN
  input  logic              lsb_first,
`endif
  input  logic [DIV_W-1:0]  clk_div,
  input  logic              miso,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rd_data,
  output logic              sclk,
  output logic              mosi,
  output logic [NUM_SS-1:0] ss_n
);

  localparam int CNT_W = $clog2(SPI_MAX_DATA_W);

  spi_state_t        state_q, state_d;
  spi_mode_t         mode_q, mode_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [NUM_SS-1:0] ss_n_q, ss_n_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] rd_q, rd_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              lsb_q, lsb_d, lsb_in;
  logic              tick, lead_tick, trail_tick;
  logic              sample, shift;

`ifdef SPI_MASTER_LSB_FIRST_EN
  assign lsb_in = lsb_first;
`else
  assign lsb_in = 1'b0;
`endif

  function automatic logic head_bit(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? w[0] : w[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] drop_head(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? {1'b0, w[DATA_W-1:1]} : {w[DATA_W-2:0], 1'b0};
  endfunction

  spi_clk_gen #(
    .DIV_W (DIV_W)
  ) u_clk_gen (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .run_i        (state_q != IDLE),
    .xfer_i       (state_q == XFER),
    .div_i        (div_q),
    .tick_o       (tick),
    .lead_tick_o  (lead_tick),
    .trail_tick_o (trail_tick)
  );

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    div_d     = div_q;
    ss_n_d    = ss_n_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    rd_d      = rd_q;
    done_d    = 1'b0;
    bit_cnt_d = bit_cnt_q;
    lsb_d     = lsb_q;
    sample    = mode_q.cpha ? trail_tick : lead_tick;
    shift     = mode_q.cpha ? lead_tick : trail_tick;

    unique case (state_q)
      IDLE: begin
        mosi_d = 1'b0;
        if (start) begin
          state_d     = SETUP;
          mode_d.cpol = cpol;
          mode_d.cpha = cpha;
          div_d       = clk_div;
          sclk_d      = cpol;
          lsb_d       = lsb_in;
          bit_cnt_d   = '0;
          rx_d        = '0;
          tx_d        = wr_data;
          // an out-of-range ss_sel matches no line, so nothing is selected
          for (int i = 0; i < NUM_SS; i++) begin
            ss_n_d[i] = (ss_sel != SS_W'(i));
          end
          if (!cpha) begin
            mosi_d = head_bit(wr_data, lsb_in);
            tx_d   = drop_head(wr_data, lsb_in);
          end
        end
      end
      SETUP: begin
        if (tick) state_d = XFER;
      end
      XFER: begin
        if (lead_tick || trail_tick) sclk_d = ~sclk_q;
        if (shift) begin
          mosi_d = head_bit(tx_q, lsb_q);
          tx_d   = drop_head(tx_q, lsb_q);
        end
        if (sample) begin
          rx_d = lsb_q ? {miso, rx_q[DATA_W-1:1]} : {rx_q[DATA_W-2:0], miso};
        end
        if (trail_tick) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == CNT_W'(DATA_W - 1)) state_d = HOLD;
        end
      end
      HOLD: begin
        if (tick) begin
          state_d = IDLE;
          ss_n_d  = '1;
          done_d  = 1'b1;
          rd_d    = rx_q;
          mosi_d  = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mode_q    <= '0;
      div_q     <= '0;
      ss_n_q    <= '1;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      tx_q      <= '0;
      rx_q      <= '0;
      rd_q      <= '0;
      done_q    <= 1'b0;
      bit_cnt_q <= '0;
      lsb_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      div_q     <= div_d;
      ss_n_q    <= ss_n_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      rd_q      <= rd_d;
      done_q    <= done_d;
      bit_cnt_q <= bit_cnt_d;
      lsb_q     <= lsb_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign rd_data = rd_q;
  assign sclk    = sclk_q;
  assign mosi    = mosi_q;
  assign ss_n    = ss_n_q;

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL have parameter DATA_W, default 16, bits per transfer (legal 4..32).
REQ-002 SHALL have parameter NUM_SS, default 4, number of slave-select lines (legal 1..8).
REQ-003 SHALL have parameter DIV_W, default 8, width of the clock-divider input.
REQ-004 clk  in  1  system clock; all logic on its rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 start  in  1  one-cycle request; accepted only when busy=0.
REQ-007 wr_data  in  DATA_W  word to shift out on mosi.
REQ-008 ss_sel  in  $clog2(NUM_SS) (min 1)  index of the slave to select.
REQ-009 cpol, cpha  in  1 each  SPI mode bits.
REQ-010 clk_div  in  DIV_W  half-period H = clk_div+1 clk cycles.
REQ-011 busy  out  1  transfer in progress.
REQ-012 done  out  1  one-cycle pulse at transfer end.
REQ-013 rd_data  out  DATA_W  word captured from miso.
REQ-014 sclk, mosi  out  1 each;  miso  in  1;  ss_n  out  NUM_SS  active-low selects.

Function
REQ-015 SHALL latch wr_data, ss_sel, cpol, cpha and clk_div on the accepted start cycle; later input changes SHALL NOT affect the transfer.
REQ-016 SHALL implement FSM IDLE -> SETUP (H cycles) -> XFER (2*DATA_W*H cycles) -> HOLD (H cycles) -> IDLE.
REQ-017 busy and ss_n[ss_sel]=0 SHALL take effect the cycle after start; all other ss_n bits stay 1; ss_sel >= NUM_SS SHALL run the transfer with no select asserted.
REQ-018 In XFER, sclk SHALL toggle every H cycles, giving exactly 2*DATA_W edges; in IDLE, sclk SHALL follow the registered cpol.
REQ-019 cpha=0: first bit on mosi at SETUP entry, miso sampled on leading edges, mosi changes on trailing edges; cpha=1: mosi changes on leading edges, miso sampled on trailing edges.
REQ-020 Bit order SHALL be MSB first (see REQ-029).
REQ-021 miso SHALL be sampled on the clk edge that drives sclk to the sampling level.
REQ-022 On leaving HOLD: ss_n SHALL go all-ones, busy SHALL go 0, done SHALL be 1 for one cycle, and rd_data SHALL update in that same cycle and hold until the next done.
REQ-023 done SHALL occur exactly (2*DATA_W+2)*H+1 cycles after the start cycle.
REQ-024 start while busy=1 SHALL be ignored with no side effects; start in the done cycle SHALL be accepted, giving >=1 cycle of ss_n high between frames.
REQ-025 mosi SHALL be 0 in IDLE.

Reset
REQ-026 rst_n=0 at any clk edge, including mid-transfer, SHALL force IDLE on that edge: sclk=0, mosi=0, ss_n=all ones, busy=0, done=0, rd_data=0, with the divider and bit counters cleared.
REQ-027 The partial word of an aborted transfer SHALL be discarded and no done SHALL be generated.

Configuration
REQ-028 Without macro SPI_MASTER_LSB_FIRST_EN: MSB-first only, and the lsb_first port SHALL be absent.
REQ-029 With SPI_MASTER_LSB_FIRST_EN: add input lsb_first (1 bit), latched at start; when 1, bit 0 is transmitted first and received bits fill rd_data from bit 0 upward.

Structure
REQ-030 Package spi_pkg SHALL hold typedef spi_state_t (IDLE, SETUP, XFER, HOLD), typedef spi_mode_t {cpol, cpha}, and constants SPI_MAX_DATA_W=32 and SPI_MAX_SS=8.
REQ-031 Sub-module spi_clk_gen SHALL hold the divider counter and emit one-cycle lead_tick/trail_tick strobes; spi_master SHALL own the FSM, shift registers and selects.

Verification
REQ-032 Mode 0, DATA_W=16, clk_div=0, wr_data=16'hA5C3, miso looped to mosi -> rd_data=16'hA5C3, done at start+35, 16 rising sclk edges.
REQ-033 Modes 1/2/3, clk_div=3, wr_data=16'h8001, slave model returns 16'h1234 -> rd_data=16'h1234; sclk idle level equals cpol; mosi is stable at every sampling edge.
REQ-034 ss_sel=2, NUM_SS=4 -> ss_n=4'b1011 throughout busy; ss_sel=5 with NUM_SS=8 -> ss_n[5] only; start pulsed mid-transfer -> ignored, with exactly one done.
REQ-035 rst_n=0 after 5 sclk edges -> next cycle ss_n all ones, sclk=0, busy=0; no done; rd_data=0.
REQ-036 Back-to-back: start in the done cycle with wr_data=16'h00FF -> ss_n high exactly 1 cycle; second rd_data correct. With SPI_MASTER_LSB_FIRST_EN and lsb_first=1, wr_data=16'h0001 -> the first mosi bit is 1.
